// File: rtl/bias_bank_loader.sv
// Bias table loader: streams bias lanes into an N_CONV x N_GRP table of
// N_adder_tree-lane words, then serves single-cycle-latency word reads.
module bias_bank_loader #(
  parameter int N_adder_tree = 16,
  parameter int BIAS_W       = 18,
  parameter int N_CONV       = 5,
  parameter int N_GRP        = 8,
  localparam int U_W = (N_CONV > 2) ? $clog2(N_CONV) : 1,
  localparam int Z_W = (N_GRP > 2) ? $clog2(N_GRP) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_start,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [BIAS_W-1:0]              ld_data,
  output logic                           load_done,
  output logic                           table_valid,
  input  logic                           rd_req,
  input  logic [U_W-1:0]                 u,
  input  logic [Z_W-1:0]                 z,
  output logic [BIAS_W*N_adder_tree-1:0] bias,
  output logic                           bias_valid
);

  localparam int N_ENT = N_CONV * N_GRP;
  localparam int LC_W  = (N_adder_tree > 2) ? $clog2(N_adder_tree) : 1;
  localparam int EC_W  = (N_ENT > 2) ? $clog2(N_ENT) : 1;
  localparam int OUT_W = BIAS_W * N_adder_tree;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LC_W-1:0]  lc_q, lc_d;
  logic [EC_W-1:0]  ec_q, ec_d;
  logic             tv_q, tv_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] bias_q, bias_d;
  logic             bv_q, bv_d;

  // Storage is deliberately left out of reset; table_valid gates its use.
  logic [BIAS_W-1:0] mem_q [N_ENT][N_adder_tree];

  logic             acc;
  logic             lc_last;
  logic             beat_last;
  logic             in_range;
  logic [31:0]      u_ext;
  logic [31:0]      z_ext;
  logic [31:0]      idx_ext;
  logic [EC_W-1:0]  rd_idx;
  logic [OUT_W-1:0] rd_word;

  assign ld_ready    = (state_q == LOAD);
  assign load_done   = done_q;
  assign table_valid = tv_q;
  assign bias        = bias_q;
  assign bias_valid  = bv_q;

  assign acc       = ld_valid & ld_ready;
  assign lc_last   = (lc_q == LC_W'(N_adder_tree - 1));
  assign beat_last = lc_last & (ec_q == EC_W'(N_ENT - 1));

  assign u_ext    = 32'(u);
  assign z_ext    = 32'(z);
  assign in_range = (u_ext < N_CONV) && (z_ext < N_GRP);
  assign idx_ext  = in_range ? (u_ext * N_GRP + z_ext) : 32'd0;
  assign rd_idx   = EC_W'(idx_ext);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_adder_tree; k++) begin
      rd_word[BIAS_W*k +: BIAS_W] = mem_q[rd_idx][k];
    end
  end

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    ec_d    = ec_q;
    tv_d    = tv_q;
    done_d  = 1'b0;
    bias_d  = bias_q;
    bv_d    = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (load_start) begin
          state_d = LOAD;
          tv_d    = 1'b0;
          lc_d    = '0;
          ec_d    = '0;
        end else if (rd_req && state_q == READY) begin
          bv_d   = 1'b1;
          bias_d = in_range ? rd_word : '0;
        end
      end
      LOAD: begin
        if (acc) begin
          if (beat_last) begin
            state_d = READY;
            done_d  = 1'b1;
            tv_d    = 1'b1;
            lc_d    = '0;
            ec_d    = '0;
          end else if (lc_last) begin
            lc_d = '0;
            ec_d = ec_q + 1'b1;
          end else begin
            lc_d = lc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lc_q    <= '0;
      ec_q    <= '0;
      tv_q    <= 1'b0;
      done_q  <= 1'b0;
      bias_q  <= '0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      ec_q    <= ec_d;
      tv_q    <= tv_d;
      done_q  <= done_d;
      bias_q  <= bias_d;
      bv_q    <= bv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && acc) begin
      mem_q[ec_q][lc_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_bias_bank_loader.sv
// Directed bench for bias_bank_loader with 2 lanes, 3 convs, 2 groups
// (12-beat table load, U_W=2 so u=3 is addressable but out of range).
module tb_bias_bank_loader;

  localparam int NA = 2;
  localparam int BW = 18;
  localparam int NC = 3;
  localparam int NG = 2;
  localparam int UW = 2;
  localparam int ZW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_start;
  logic            ld_valid;
  logic            ld_ready;
  logic [BW-1:0]   ld_data;
  logic            load_done;
  logic            table_valid;
  logic            rd_req;
  logic [UW-1:0]   u;
  logic [ZW-1:0]   z;
  logic [BW*NA-1:0] bias;
  logic            bias_valid;

  int errors = 0;
  int checks = 0;

  bias_bank_loader #(
    .N_adder_tree(NA),
    .BIAS_W      (BW),
    .N_CONV      (NC),
    .N_GRP       (NG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .load_done  (load_done),
    .table_valid(table_valid),
    .rd_req     (rd_req),
    .u          (u),
    .z          (z),
    .bias       (bias),
    .bias_valid (bias_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] w(input int hi, input int lo);
    logic [BW-1:0] h;
    logic [BW-1:0] l;
    h = BW'(hi);
    l = BW'(lo);
    return 64'({h, l});
  endfunction

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    rd_req = 1'b0;
    u = '0;
    z = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_table_valid", 64'(table_valid), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_bias", 64'(bias), 64'd0);
    chk("rst_bias_valid", 64'(bias_valid), 64'd0);

    // Full load, no gaps.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_ready", 64'(ld_ready), 64'd1);
    for (int i = 1; i <= 12; i++) begin
      ld_valid = 1'b1;
      ld_data = BW'(i);
      step();
      chk($sformatf("done_b%0d", i), 64'(load_done), 64'(i == 12));
    end
    ld_valid = 1'b0;
    chk("full_table_valid", 64'(table_valid), 64'd1);
    chk("full_ld_ready_off", 64'(ld_ready), 64'd0);

    rd_req = 1'b1;
    u = 2'd1;
    z = 1'b0;
    step();
    chk("done_one_cycle", 64'(load_done), 64'd0);
    chk("rd10_bias", 64'(bias), w(6, 5));
    chk("rd10_valid", 64'(bias_valid), 64'd1);

    // Back-to-back reads.
    u = 2'd0; z = 1'b0;
    step();
    chk("b2b00", 64'(bias), w(2, 1));
    u = 2'd0; z = 1'b1;
    step();
    chk("b2b01", 64'(bias), w(4, 3));
    u = 2'd1; z = 1'b1;
    step();
    chk("b2b11", 64'(bias), w(8, 7));
    chk("b2b11_valid", 64'(bias_valid), 64'd1);
    rd_req = 1'b0;
    step();
    chk("idle_valid", 64'(bias_valid), 64'd0);
    chk("idle_hold", 64'(bias), w(8, 7));

    // Out-of-range and last entry.
    rd_req = 1'b1;
    u = 2'd3; z = 1'b0;
    step();
    chk("oor_bias", 64'(bias), 64'd0);
    chk("oor_valid", 64'(bias_valid), 64'd1);
    u = 2'd2; z = 1'b1;
    step();
    chk("rd21", 64'(bias), w(12, 11));

    // load_start wins over a simultaneous read.
    u = 2'd0; z = 1'b0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    rd_req = 1'b0;
    chk("coll_valid", 64'(bias_valid), 64'd0);
    chk("coll_bias_hold", 64'(bias), w(12, 11));
    chk("coll_ld_ready", 64'(ld_ready), 64'd1);
    chk("coll_table_valid", 64'(table_valid), 64'd0);

    // Throttled reload: 3 idle cycles after beat 4, with a read and a
    // stray load_start in the gap; done must land 3 cycles later.
    begin
      int beat = 1;
      for (int k = 0; k < 15; k++) begin
        if (k >= 4 && k < 7) begin
          ld_valid = 1'b0;
          rd_req = (k == 5);
          load_start = (k == 6);
        end else begin
          ld_valid = 1'b1;
          ld_data = BW'(beat);
          rd_req = 1'b0;
          load_start = 1'b0;
          beat++;
        end
        step();
        chk($sformatf("thr_done_k%0d", k), 64'(load_done), 64'(k == 14));
        if (k == 5) chk("load_read_valid", 64'(bias_valid), 64'd0);
      end
    end
    ld_valid = 1'b0;
    load_start = 1'b0;
    rd_req = 1'b1;
    u = 2'd1; z = 1'b0;
    step();
    chk("thr_rd10", 64'(bias), w(6, 5));
    u = 2'd2; z = 1'b1;
    step();
    chk("thr_rd21", 64'(bias), w(12, 11));
    rd_req = 1'b0;

    // Reset in the middle of a load.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ld_valid = 1'b1;
      ld_data = BW'(50 + i);
      step();
    end
    rst = 1'b1;
    load_start = 1'b1;
    rd_req = 1'b1;
    step();
    rst = 1'b0;
    load_start = 1'b0;
    ld_valid = 1'b0;
    chk("mrst_table_valid", 64'(table_valid), 64'd0);
    chk("mrst_ld_ready", 64'(ld_ready), 64'd0);
    chk("mrst_bias", 64'(bias), 64'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        step();
        if (load_done) seen++;
      end
      chk("mrst_no_done", 64'(seen), 64'd0);
    end
    chk("idle_read_valid", 64'(bias_valid), 64'd0);
    rd_req = 1'b0;

    // Fresh load after reset, new values.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    begin
      int got = 0;
      for (int i = 1; i <= 12; i++) begin
        ld_valid = 1'b1;
        ld_data = BW'(100 + i);
        step();
        if (load_done) got = i;
      end
      chk("fresh_done_at", 64'(got), 64'd12);
    end
    ld_valid = 1'b0;
    rd_req = 1'b1;
    u = 2'd0; z = 1'b1;
    step();
    chk("fresh_rd01", 64'(bias), w(104, 103));
    u = 2'd2; z = 1'b0;
    step();
    chk("fresh_rd20", 64'(bias), w(110, 109));
    rd_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
